id_skid: RTL and testbench

Decode-stage entry buffer: the receiving end of the IF→ID valid/ready handshake. It accepts one fetched PC and instruction per cycle from the fetch stage and holds up to two entries (main + skid), so that `ID_ready_o` is a registered function of buffer state. It presents the head entry, with RV64 instruction fields split out, to the execute stage under a second valid/ready handshake, and discards all held entries on a decode flush.

---
 rtl/id_skid_if.sv | 32 +++
 rtl/id_skid.sv | 91 +++++++++
 tb/tb_id_skid.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/id_skid_if.sv
// Handshake bundle for id_skid: fetch-side offer, execute-side head with decoded fields.
// The slave modport is the buffer; the master modport is whoever drives fetch/execute.
interface id_skid_if #(
    parameter int unsigned PcWidth   = 64,
    parameter int unsigned InstWidth = 32
);
    logic                 flush;
    logic                 if_valid;
    logic [PcWidth-1:0]   if_pc;
    logic [InstWidth-1:0] if_inst;
    logic                 id_ready;
    logic                 id_valid;
    logic                 ex_ready;
    logic [PcWidth-1:0]   id_pc;
    logic [InstWidth-1:0] id_inst;
    logic [6:0]           opcode;
    logic [4:0]           rd;
    logic [2:0]           funct3;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [63:0]          imm_i;

    modport master (
        output flush, if_valid, if_pc, if_inst, ex_ready,
        input  id_ready, id_valid, id_pc, id_inst, opcode, rd, funct3, rs1, rs2, imm_i
    );

    modport slave (
        input  flush, if_valid, if_pc, if_inst, ex_ready,
        output id_ready, id_valid, id_pc, id_inst, opcode, rd, funct3, rs1, rs2, imm_i
    );
endinterface

// File: rtl/id_skid.sv
// Decode-stage entry buffer: two-deep (main + skid) receiver of the IF->ID handshake,
// presenting the head entry with RV64 fields split out toward execute.
module id_skid #(
    parameter int unsigned PcWidth   = 64,
    parameter int unsigned InstWidth = 32
) (
    input logic        clk,
    input logic        rst,
    id_skid_if.slave   bus
);

    logic                 main_v_q, main_v_d;
    logic [PcWidth-1:0]   main_pc_q, main_pc_d;
    logic [InstWidth-1:0] main_inst_q, main_inst_d;
    logic                 skid_v_q, skid_v_d;
    logic [PcWidth-1:0]   skid_pc_q, skid_pc_d;
    logic [InstWidth-1:0] skid_inst_q, skid_inst_d;

    logic ready;
    logic push;
    logic pop;

    // Ready depends only on occupancy, never on ex_ready.
    assign ready = !rst && !skid_v_q;
    assign push  = bus.if_valid && ready;
    assign pop   = main_v_q && bus.ex_ready;

    always_comb begin
        main_v_d    = main_v_q;
        main_pc_d   = main_pc_q;
        main_inst_d = main_inst_q;
        skid_v_d    = skid_v_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        if (bus.flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q) begin
            if (push) begin
                main_v_d    = 1'b1;
                main_pc_d   = bus.if_pc;
                main_inst_d = bus.if_inst;
            end
        end else if (pop && skid_v_q) begin
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
            skid_v_d    = 1'b0;
        end else if (pop) begin
            if (push) begin
                main_pc_d   = bus.if_pc;
                main_inst_d = bus.if_inst;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (push) begin
            skid_v_d    = 1'b1;
            skid_pc_d   = bus.if_pc;
            skid_inst_d = bus.if_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            main_pc_q   <= '0;
            main_inst_q <= '0;
            skid_v_q    <= 1'b0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
        end else begin
            main_v_q    <= main_v_d;
            main_pc_q   <= main_pc_d;
            main_inst_q <= main_inst_d;
            skid_v_q    <= skid_v_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
        end
    end

    assign bus.id_ready = ready;
    assign bus.id_valid = main_v_q;
    assign bus.id_pc    = main_pc_q;
    assign bus.id_inst  = main_inst_q;
    assign bus.opcode   = main_inst_q[6:0];
    assign bus.rd       = main_inst_q[11:7];
    assign bus.funct3   = main_inst_q[14:12];
    assign bus.rs1      = main_inst_q[19:15];
    assign bus.rs2      = main_inst_q[24:20];
    assign bus.imm_i    = {{52{main_inst_q[31]}}, main_inst_q[31:20]};

endmodule

// File: tb/tb_id_skid.sv
// Self-checking bench for id_skid: directed vector table, hand-written reset sequences,
// and a random run against a queue model of the two-entry buffer.
module tb_id_skid;
    localparam int unsigned PcWidth   = 64;
    localparam int unsigned InstWidth = 32;

    localparam logic [31:0] Addi = 32'h00A00093;
    localparam logic [31:0] X1   = 32'h12345678;
    localparam logic [31:0] X2   = 32'h87654321;
    localparam logic [31:0] Neg  = 32'hFFF00093;

    typedef struct {
        bit          rst;
        bit          flush;
        bit          vld;
        logic [63:0] pc;
        logic [31:0] inst;
        bit          exr;
        bit          e_ready;
        bit          e_valid;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        bit          chk_f;
        logic [6:0]  e_op;
        logic [4:0]  e_rd;
        logic [2:0]  e_f3;
        logic [4:0]  e_rs1;
        logic [4:0]  e_rs2;
        logic [63:0] e_imm;
    } vec_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_skid_if #(.PcWidth(PcWidth), .InstWidth(InstWidth)) bus ();

    id_skid #(.PcWidth(PcWidth), .InstWidth(InstWidth)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit fl, input bit vld, input logic [63:0] pc,
                         input logic [31:0] inst, input bit exr);
        rst          = r;
        bus.flush    = fl;
        bus.if_valid = vld;
        bus.if_pc    = pc;
        bus.if_inst  = inst;
        bus.ex_ready = exr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t v(bit fl, bit vld, logic [63:0] pc, logic [31:0] inst, bit exr,
                               bit er, bit ev, logic [63:0] epc, logic [31:0] einst);
        vec_t t;
        t.rst = 1'b0; t.flush = fl; t.vld = vld; t.pc = pc; t.inst = inst; t.exr = exr;
        t.e_ready = er; t.e_valid = ev; t.e_pc = epc; t.e_inst = einst;
        t.chk_f = 1'b0; t.e_op = '0; t.e_rd = '0; t.e_f3 = '0; t.e_rs1 = '0; t.e_rs2 = '0;
        t.e_imm = '0;
        return t;
    endfunction

    function automatic vec_t vf(vec_t b, logic [6:0] op, logic [4:0] rd, logic [2:0] f3,
                                logic [4:0] rs1, logic [4:0] rs2, logic [63:0] imm);
        vec_t t = b;
        t.chk_f = 1'b1; t.e_op = op; t.e_rd = rd; t.e_f3 = f3;
        t.e_rs1 = rs1; t.e_rs2 = rs2; t.e_imm = imm;
        return t;
    endfunction

    vec_t vecs[$];
    ent_t q[$];

    initial begin
        // Streaming with ex_ready high
        vecs.push_back(vf(v(0, 1, 64'h0, Addi, 1, 1, 1, 64'h0, Addi), 7'h13, 5'd1, 3'd0, 5'd0,
                          5'd10, 64'd10));
        vecs.push_back(v(0, 1, 64'h4, Addi, 1, 1, 1, 64'h4, Addi));
        vecs.push_back(vf(v(0, 1, 64'h8, Addi, 1, 1, 1, 64'h8, Addi), 7'h13, 5'd1, 3'd0, 5'd0,
                          5'd10, 64'd10));
        vecs.push_back(v(0, 0, 64'h0, 32'h0, 1, 1, 0, 64'h0, 32'h0));
        // Backpressure: fill, refuse third offer, drain in order
        vecs.push_back(vf(v(0, 1, 64'h100, X1, 0, 1, 1, 64'h100, X1), 7'h78, 5'd12, 3'd5,
                          5'd8, 5'd3, 64'h123));
        vecs.push_back(v(0, 1, 64'h104, X2, 0, 0, 1, 64'h100, X1));
        vecs.push_back(v(0, 1, 64'h108, Addi, 0, 0, 1, 64'h100, X1));
        vecs.push_back(vf(v(0, 1, 64'h108, Addi, 1, 1, 1, 64'h104, X2), 7'h21, 5'd6, 3'd4,
                          5'd10, 5'h16, 64'hFFFF_FFFF_FFFF_F876));
        vecs.push_back(v(0, 1, 64'h108, Addi, 1, 1, 1, 64'h108, Addi));
        vecs.push_back(v(0, 0, 64'h0, 32'h0, 1, 1, 0, 64'h0, 32'h0));
        // Flush of a full buffer with a push offered
        vecs.push_back(v(0, 1, 64'h200, Addi, 0, 1, 1, 64'h200, Addi));
        vecs.push_back(v(0, 1, 64'h204, Addi, 0, 0, 1, 64'h200, Addi));
        vecs.push_back(v(1, 1, 64'h208, Addi, 0, 1, 0, 64'h0, 32'h0));
        vecs.push_back(v(0, 0, 64'h0, 32'h0, 0, 1, 0, 64'h0, 32'h0));
        // Flush together with push and pop
        vecs.push_back(v(0, 1, 64'h300, X1, 1, 1, 1, 64'h300, X1));
        vecs.push_back(v(1, 1, 64'h304, X2, 1, 1, 0, 64'h0, 32'h0));
        vecs.push_back(v(0, 0, 64'h0, 32'h0, 1, 1, 0, 64'h0, 32'h0));
        // Negative immediate
        vecs.push_back(vf(v(0, 1, 64'h400, Neg, 0, 1, 1, 64'h400, Neg), 7'h13, 5'd1, 3'd0,
                          5'd0, 5'h1F, 64'hFFFF_FFFF_FFFF_FFFF));
        vecs.push_back(v(0, 0, 64'h0, 32'h0, 1, 1, 0, 64'h0, 32'h0));

        // Reset held three cycles with a pending offer
        drive(1, 0, 1, 64'h50, Addi, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", 64'(bus.id_ready), 64'd0);
            chk("rst_valid", 64'(bus.id_valid), 64'd0);
        end
        drive(0, 0, 0, 64'h0, 32'h0, 1);
        tick();
        chk("rel_ready", 64'(bus.id_ready), 64'd1);
        chk("rel_valid", 64'(bus.id_valid), 64'd0);
        chk("rel_pc", bus.id_pc, 64'd0);
        chk("rel_inst", 64'(bus.id_inst), 64'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].vld, vecs[i].pc, vecs[i].inst,
                  vecs[i].exr);
            tick();
            chk($sformatf("v%0d_ready", i), 64'(bus.id_ready), 64'(vecs[i].e_ready));
            chk($sformatf("v%0d_valid", i), 64'(bus.id_valid), 64'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_pc", i), bus.id_pc, vecs[i].e_pc);
                chk($sformatf("v%0d_inst", i), 64'(bus.id_inst), 64'(vecs[i].e_inst));
            end
            if (vecs[i].chk_f) begin
                chk($sformatf("v%0d_opcode", i), 64'(bus.opcode), 64'(vecs[i].e_op));
                chk($sformatf("v%0d_rd", i), 64'(bus.rd), 64'(vecs[i].e_rd));
                chk($sformatf("v%0d_funct3", i), 64'(bus.funct3), 64'(vecs[i].e_f3));
                chk($sformatf("v%0d_rs1", i), 64'(bus.rs1), 64'(vecs[i].e_rs1));
                chk($sformatf("v%0d_rs2", i), 64'(bus.rs2), 64'(vecs[i].e_rs2));
                chk($sformatf("v%0d_imm", i), bus.imm_i, vecs[i].e_imm);
            end
        end

        // Reset while full
        drive(0, 0, 1, 64'h500, X1, 0);
        tick();
        drive(0, 0, 1, 64'h504, X2, 0);
        tick();
        chk("mid_full_ready", 64'(bus.id_ready), 64'd0);
        drive(1, 0, 1, 64'h508, Addi, 0);
        tick();
        chk("mid_rst_ready", 64'(bus.id_ready), 64'd0);
        chk("mid_rst_valid", 64'(bus.id_valid), 64'd0);
        drive(0, 0, 0, 64'h0, 32'h0, 0);
        tick();
        chk("mid_rel_ready", 64'(bus.id_ready), 64'd1);
        chk("mid_rel_valid", 64'(bus.id_valid), 64'd0);
        chk("mid_rel_pc", bus.id_pc, 64'd0);
        chk("mid_rel_inst", 64'(bus.id_inst), 64'd0);

        // Random traffic against a queue model; starts from a flushed, empty buffer
        drive(0, 1, 0, 64'h0, 32'h0, 0);
        tick();
        q.delete();
        for (int i = 0; i < 10000; i++) begin
            bit          fl;
            bit          vld;
            bit          exr;
            bit          do_pop;
            bit          do_push;
            logic [63:0] pc;
            logic [31:0] inst;
            fl   = ($urandom_range(99) < 3);
            vld  = ($urandom_range(99) < 70);
            exr  = ($urandom_range(99) < 50);
            pc   = {$urandom, $urandom};
            inst = $urandom;
            drive(0, fl, vld, pc, inst, exr);
            tick();
            if (fl) begin
                q.delete();
            end else begin
                do_pop  = (q.size() > 0) && exr;
                do_push = vld && (q.size() < 2);
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back('{pc: pc, inst: inst});
            end
            chk("rnd_ready", 64'(bus.id_ready), 64'(q.size() < 2));
            chk("rnd_valid", 64'(bus.id_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("rnd_pc", bus.id_pc, q[0].pc);
                chk("rnd_inst", 64'(bus.id_inst), 64'(q[0].inst));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
